// File: rtl/ntm_scalar_summation_pkg.sv
// Shared types, default sizes and the saturating adder for the NTM scalar summation stage.
// Widths up to SAT_W bits are supported by the adder.
package ntm_scalar_summation_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam int DATA_SIZE_DEF = 9;
    localparam int ACC_SIZE_DEF  = 16;
    localparam int CNT_SIZE_DEF  = 8;
    localparam int SAT_W         = 32;

    // Returns {carry_out, sum}; sum clamps to all-ones of 'width' bits on carry.
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int unsigned      width
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ({{SAT_W{1'b0}}, 1'b1} << width) - {{SAT_W{1'b0}}, 1'b1};
        if (sum > lim) begin
            return {1'b1, lim[SAT_W-1:0]};
        end
        return {1'b0, sum[SAT_W-1:0]};
    endfunction

endpackage

// File: rtl/ntm_scalar_summation_accumulator.sv
// Accumulates a run of unsigned adder sums into one saturating total with a
// held valid/ready result and a sticky per-run overflow flag.
module ntm_scalar_summation_accumulator
    import ntm_scalar_summation_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int ACC_SIZE  = ACC_SIZE_DEF,
    parameter int CNT_SIZE  = CNT_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_SIZE-1:0]  length_in,
    input  logic                 data_in_valid,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic                 data_in_ready,
    output logic                 data_out_valid,
    output logic [ACC_SIZE-1:0]  data_out,
    output logic                 overflow,
    input  logic                 data_out_ready,
    output logic                 busy
);

    state_t              r_state;
    state_t              w_state_next;
    logic [ACC_SIZE-1:0] r_acc;
    logic [CNT_SIZE-1:0] r_cnt;
    logic                r_ovf;
    logic                w_load;
    logic                w_beat;
    logic [SAT_W:0]      w_sum;

    assign w_sum = sat_add(SAT_W'(r_acc), SAT_W'(data_in), ACC_SIZE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake outputs depend only on state, never on the valid/ready inputs.
    always_comb begin
        w_state_next   = r_state;
        data_in_ready  = 1'b0;
        data_out_valid = 1'b0;
        busy           = 1'b0;
        w_load         = 1'b0;
        w_beat         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = (length_in == '0) ? OUTPUT : ACCUM;
                end
            end
            ACCUM: begin
                data_in_ready = 1'b1;
                busy          = 1'b1;
                w_beat        = data_in_valid;
                if (data_in_valid && (r_cnt == CNT_SIZE'(1))) begin
                    w_state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                data_out_valid = 1'b1;
                busy           = 1'b1;
                if (data_out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Once saturated, further adds keep carrying out, so acc stays at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_load) begin
            r_acc <= '0;
            r_cnt <= length_in;
            r_ovf <= 1'b0;
        end else if (w_beat) begin
            r_acc <= ACC_SIZE'(w_sum);
            r_cnt <= r_cnt - CNT_SIZE'(1);
            r_ovf <= r_ovf | w_sum[SAT_W];
        end
    end

    assign data_out = r_acc;
    assign overflow = r_ovf;

endmodule
